// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, applies the single delay-slot redirect, and freezes fetch on hazard or counted stalls.
// Optional FETCH_SEQ_PERF_EN adds free-running stall and redirect counters.
//
// state | meaning
// BOOT  | one post-reset cycle, NOP to decode, PC at RESET_PC
// RUN   | normal sequential fetch, PC advances by 4
// DELAY | fetching the delay slot; the pending target loads next
// HOLD  | level stall from the hazard unit, PC frozen, NOP to decode
// MC    | counted multi-cycle stall, PC frozen, NOP to decode
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter int          CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_in,
  input  logic             mc_start_in,
  input  logic [CNT_W-1:0] mc_cycles_in,
  input  logic             redirect_in,
  input  logic [31:0]      redirect_target_in,
  output logic [31:0]      pc_out,
  output logic             pc_en_out,
  output logic             nop_sel_out,
  output logic             fetch_valid_out,
`ifdef FETCH_SEQ_PERF_EN
  output logic [31:0]      stall_count_out,
  output logic [31:0]      redirect_count_out,
`endif
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_RUN   = 3'd1,
    S_DELAY = 3'd2,
    S_HOLD  = 3'd3,
    S_MC    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Plain vector rather than state_t so the illegal codes 5-7 stay representable.
  logic [2:0]       state_q;
  logic [2:0]       ret_q;
  logic [31:0]      pc_q;
  logic [31:0]      target_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      pc_next;
  logic             mc_go;
  logic             fetching;

  assign pc_next  = pc_q + 32'd4;
  assign mc_go    = mc_start_in && (mc_cycles_in != '0);
  assign fetching = (state_q == S_RUN) || (state_q == S_DELAY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_BOOT;
      ret_q    <= S_RUN;
      pc_q     <= RESET_PC;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_BOOT: state_q <= S_RUN;
        S_RUN: begin
          if (mc_go) begin
            // The current fetch is kept; the PC step is deferred to the end of the stall.
            cnt_q   <= mc_cycles_in;
            state_q <= S_MC;
            if (redirect_in) begin
              target_q <= redirect_target_in;
              ret_q    <= S_DELAY;
            end else begin
              ret_q <= S_RUN;
            end
          end else if (stall_in) begin
            ret_q   <= S_RUN;
            state_q <= S_HOLD;
          end else if (redirect_in) begin
            target_q <= redirect_target_in;
            pc_q     <= pc_next;
            state_q  <= S_DELAY;
          end else begin
            pc_q <= pc_next;
          end
        end
        S_DELAY: begin
          if (stall_in) begin
            ret_q   <= S_DELAY;
            state_q <= S_HOLD;
          end else begin
            pc_q    <= target_q;
            state_q <= S_RUN;
          end
        end
        S_HOLD: begin
          if (!stall_in) state_q <= ret_q;
        end
        S_MC: begin
          if (cnt_q <= CNT_ONE) begin
            cnt_q   <= '0;
            pc_q    <= pc_next;
            state_q <= stall_in ? S_HOLD : ret_q;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redir_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if ((state_q == S_HOLD) || (state_q == S_MC)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((state_q == S_RUN) && redirect_in && (mc_go || !stall_in))
        redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign stall_count_out    = stall_cnt_q;
  assign redirect_count_out = redir_cnt_q;
`endif

  assign pc_out          = pc_q;
  assign pc_en_out       = fetching;
  assign nop_sel_out     = !fetching;
  assign fetch_valid_out = fetching;
  assign state_out       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: per-cycle stimulus with the expected post-edge PC/valid/state queued alongside.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC   = 32'h00400000;
  localparam logic [2:0]  ST_BOOT  = 3'd0;
  localparam logic [2:0]  ST_RUN   = 3'd1;
  localparam logic [2:0]  ST_DELAY = 3'd2;
  localparam logic [2:0]  ST_HOLD  = 3'd3;
  localparam logic [2:0]  ST_MC    = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in;
  logic        mc_start_in;
  logic [3:0]  mc_cycles_in;
  logic        redirect_in;
  logic [31:0] redirect_target_in;
  logic [31:0] pc_out;
  logic        pc_en_out;
  logic        nop_sel_out;
  logic        fetch_valid_out;
  logic [2:0]  state_out;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] stall_count_out;
  logic [31:0] redirect_count_out;
`endif

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(.RESET_PC(RST_PC), .CNT_W(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .stall_in           (stall_in),
    .mc_start_in        (mc_start_in),
    .mc_cycles_in       (mc_cycles_in),
    .redirect_in        (redirect_in),
    .redirect_target_in (redirect_target_in),
    .pc_out             (pc_out),
    .pc_en_out          (pc_en_out),
    .nop_sel_out        (nop_sel_out),
    .fetch_valid_out    (fetch_valid_out),
`ifdef FETCH_SEQ_PERF_EN
    .stall_count_out    (stall_count_out),
    .redirect_count_out (redirect_count_out),
`endif
    .state_out          (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        s;
    logic        m;
    logic [3:0]  n;
    logic        rd;
    logic [31:0] t;
    logic [31:0] pc;
    logic        v;
    logic [2:0]  st;
  } step_t;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic [2:0]  st;
  } exp_t;

  exp_t sb[$];

  function automatic step_t mk(logic r, logic s, logic m, logic [3:0] n, logic rd,
                               logic [31:0] t, logic [31:0] pc, logic v, logic [2:0] st);
    step_t x;
    x.r = r; x.s = s; x.m = m; x.n = n; x.rd = rd; x.t = t;
    x.pc = pc; x.v = v; x.st = st;
    return x;
  endfunction

  task automatic drive(input step_t x);
    reset              = x.r;
    stall_in           = x.s;
    mc_start_in        = x.m;
    mc_cycles_in       = x.n;
    redirect_in        = x.rd;
    redirect_target_in = x.t;
  endtask

  task automatic push_exp(input step_t x);
    exp_t e;
    e.pc = x.pc; e.v = x.v; e.st = x.st;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    step_t s[$];
    exp_t  e;
    for (int k = 0; k < 3; k++) s.push_back(mk(0, 0, 0, 0, 0, 0, RST_PC, 0, ST_BOOT));
    s.push_back(mk(1, 0, 0, 0, 0, 0, RST_PC,          1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0, RST_PC + 32'h4,  1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0, RST_PC + 32'h8,  1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0, RST_PC + 32'hC,  1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0, RST_PC + 32'h10, 1, ST_RUN));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      push_exp(s[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pc_out !== e.pc || fetch_valid_out !== e.v || pc_en_out !== e.v ||
          nop_sel_out !== !e.v || state_out !== e.st) begin
        errors++;
        $display("FAIL reset[%0d]: got pc=%h valid=%b en=%b nop=%b st=%0d, want pc=%h valid=%b st=%0d",
                 i, pc_out, fetch_valid_out, pc_en_out, nop_sel_out, state_out, e.pc, e.v, e.st);
      end
    end
  endtask

  task automatic test_redirect();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(1, 0, 0, 0, 1, 32'h00400100, 32'h00400014, 1, ST_DELAY));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400100, 1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400104, 1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 1, 32'h00400020, 32'h00400108, 1, ST_DELAY));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400020, 1, ST_RUN));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      push_exp(s[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pc_out !== e.pc || fetch_valid_out !== e.v || pc_en_out !== e.v ||
          nop_sel_out !== !e.v || state_out !== e.st) begin
        errors++;
        $display("FAIL redirect[%0d]: got pc=%h valid=%b en=%b nop=%b st=%0d, want pc=%h valid=%b st=%0d",
                 i, pc_out, fetch_valid_out, pc_en_out, nop_sel_out, state_out, e.pc, e.v, e.st);
      end
    end
  endtask

  task automatic test_mc();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(1, 0, 1, 3, 0, 0, 32'h00400020, 0, ST_MC));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 32'h00400020, 0, ST_MC));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 32'h00400020, 0, ST_MC));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 32'h00400024, 1, ST_RUN));
    s.push_back(mk(1, 0, 1, 0, 0, 0, 32'h00400028, 1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0040002C, 1, ST_RUN));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      push_exp(s[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pc_out !== e.pc || fetch_valid_out !== e.v || pc_en_out !== e.v ||
          nop_sel_out !== !e.v || state_out !== e.st) begin
        errors++;
        $display("FAIL mc[%0d]: got pc=%h valid=%b en=%b nop=%b st=%0d, want pc=%h valid=%b st=%0d",
                 i, pc_out, fetch_valid_out, pc_en_out, nop_sel_out, state_out, e.pc, e.v, e.st);
      end
    end
  endtask

  task automatic test_overlap();
    step_t s[$];
    exp_t  e;
    // mc + redirect together, redirect during MC dropped
    s.push_back(mk(1, 0, 1, 2, 1, 32'h00400300, 32'h0040002C, 0, ST_MC));
    s.push_back(mk(1, 0, 0, 0, 1, 32'h00400777, 32'h0040002C, 0, ST_MC));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400030, 1, ST_DELAY));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400300, 1, ST_RUN));
    // stall during MC deferred into HOLD
    s.push_back(mk(1, 0, 1, 2, 0, 0,            32'h00400300, 0, ST_MC));
    s.push_back(mk(1, 1, 0, 0, 0, 0,            32'h00400300, 0, ST_MC));
    s.push_back(mk(1, 1, 0, 0, 0, 0,            32'h00400304, 0, ST_HOLD));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400304, 1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400308, 1, ST_RUN));
    // stall beats redirect in RUN
    s.push_back(mk(1, 1, 0, 0, 1, 32'h00400999, 32'h00400308, 0, ST_HOLD));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400308, 1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h0040030C, 1, ST_RUN));
    // mc_start during HOLD dropped
    s.push_back(mk(1, 1, 0, 0, 0, 0,            32'h0040030C, 0, ST_HOLD));
    s.push_back(mk(1, 1, 1, 3, 0, 0,            32'h0040030C, 0, ST_HOLD));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h0040030C, 1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400310, 1, ST_RUN));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      push_exp(s[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pc_out !== e.pc || fetch_valid_out !== e.v || pc_en_out !== e.v ||
          nop_sel_out !== !e.v || state_out !== e.st) begin
        errors++;
        $display("FAIL overlap[%0d]: got pc=%h valid=%b en=%b nop=%b st=%0d, want pc=%h valid=%b st=%0d",
                 i, pc_out, fetch_valid_out, pc_en_out, nop_sel_out, state_out, e.pc, e.v, e.st);
      end
    end
  endtask

  task automatic test_delay_stall();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(1, 0, 0, 0, 1, 32'h00400200, 32'h00400314, 1, ST_DELAY));
    s.push_back(mk(1, 1, 0, 0, 0, 0,            32'h00400314, 0, ST_HOLD));
    s.push_back(mk(1, 1, 0, 0, 1, 32'h00400999, 32'h00400314, 0, ST_HOLD));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400314, 1, ST_DELAY));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400200, 1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00400204, 1, ST_RUN));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      push_exp(s[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pc_out !== e.pc || fetch_valid_out !== e.v || pc_en_out !== e.v ||
          nop_sel_out !== !e.v || state_out !== e.st) begin
        errors++;
        $display("FAIL delay_stall[%0d]: got pc=%h valid=%b en=%b nop=%b st=%0d, want pc=%h valid=%b st=%0d",
                 i, pc_out, fetch_valid_out, pc_en_out, nop_sel_out, state_out, e.pc, e.v, e.st);
      end
    end
  endtask

  task automatic test_wrap();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(1, 0, 0, 0, 1, 32'hFFFFFFF8, 32'h00400208, 1, ST_DELAY));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'hFFFFFFF8, 1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'hFFFFFFFC, 1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00000000, 1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0,            32'h00000004, 1, ST_RUN));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      push_exp(s[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pc_out !== e.pc || fetch_valid_out !== e.v || pc_en_out !== e.v ||
          nop_sel_out !== !e.v || state_out !== e.st) begin
        errors++;
        $display("FAIL wrap[%0d]: got pc=%h valid=%b en=%b nop=%b st=%0d, want pc=%h valid=%b st=%0d",
                 i, pc_out, fetch_valid_out, pc_en_out, nop_sel_out, state_out, e.pc, e.v, e.st);
      end
    end
  endtask

  task automatic test_illegal_state();
    bit found;
    force dut.state_q = 3'd6;
    #1;
    checks++;
    if (state_out !== 3'd6 || fetch_valid_out !== 1'b0 || nop_sel_out !== 1'b1) begin
      errors++;
      $display("FAIL illegal_decode: got st=%0d valid=%b nop=%b, want st=6 valid=0 nop=1",
               state_out, fetch_valid_out, nop_sel_out);
    end
    @(posedge clk);
    #1;
    release dut.state_q;
    found = 1'b0;
    for (int k = 0; k < 3 && !found; k++) begin
      @(negedge clk);
      if (state_out === ST_BOOT) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL illegal_recover: got st=%0d, want st=%0d within 3 cycles", state_out, ST_BOOT);
    end
  endtask

  task automatic test_reset_mid_mc();
    step_t s[$];
    exp_t  e;
    s.push_back(mk(0, 0, 0, 0, 0, 0, RST_PC, 0, ST_BOOT));
    s.push_back(mk(1, 0, 0, 0, 0, 0, RST_PC, 1, ST_RUN));
    s.push_back(mk(1, 0, 1, 8, 0, 0, RST_PC, 0, ST_MC));
    for (int k = 0; k < 3; k++) s.push_back(mk(1, 0, 0, 0, 0, 0, RST_PC, 0, ST_MC));
    s.push_back(mk(0, 0, 0, 0, 0, 0, RST_PC,          0, ST_BOOT));
    s.push_back(mk(1, 0, 0, 0, 0, 0, RST_PC,          1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0, RST_PC + 32'h4,  1, ST_RUN));
    s.push_back(mk(1, 0, 0, 0, 0, 0, RST_PC + 32'h8,  1, ST_RUN));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i]);
      push_exp(s[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pc_out !== e.pc || fetch_valid_out !== e.v || pc_en_out !== e.v ||
          nop_sel_out !== !e.v || state_out !== e.st) begin
        errors++;
        $display("FAIL reset_mid_mc[%0d]: got pc=%h valid=%b en=%b nop=%b st=%0d, want pc=%h valid=%b st=%0d",
                 i, pc_out, fetch_valid_out, pc_en_out, nop_sel_out, state_out, e.pc, e.v, e.st);
      end
    end
`ifdef FETCH_SEQ_PERF_EN
    checks++;
    if (stall_count_out !== 32'd0 || redirect_count_out !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got stall=%0d redirect=%0d, want 0 and 0",
               stall_count_out, redirect_count_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_mc();
    test_overlap();
    test_delay_stall();
    test_wrap();
    test_illegal_state();
    test_reset_mid_mc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
